// File: rtl/serv_csr_seq.sv
// rtl/serv_csr_seq.sv - beat sequencer for the W-bit-per-cycle CSR datapath
// Runs INIT/EXEC/TRAP passes of 32/W beats and pulses o_ack when the sequence ends.
module serv_csr_seq #(
  parameter  int W  = 8,
  localparam int NB = 32 / W,
  localparam int CW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_two_pass,
  input  logic          i_trap_req,
  input  logic          i_halt,
  output logic          o_busy,
  output logic          o_init,
  output logic          o_en,
  output logic          o_trap,
  output logic [CW-1:0] o_cnt,
  output logic          o_cnt0to3,
  output logic          o_cnt3,
  output logic          o_cnt7,
  output logic          o_cnt_done,
  output logic          o_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_EXEC,
    S_TRAP,
    S_ACK
  } state_t;

  // Beat indices whose bit range contains bits 0..3, bit 3, bit 7 and bit 31.
  localparam logic [CW-1:0] K_LOW  = CW'(3 / W);
  localparam logic [CW-1:0] K_BIT3 = CW'(3 / W);
  localparam logic [CW-1:0] K_BIT7 = CW'(7 / W);
  localparam logic [CW-1:0] K_LAST = CW'(NB - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          active;
  logic          last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign active = (state == S_INIT) || (state == S_EXEC) || (state == S_TRAP);
  assign last   = (cnt == K_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (i_trap_req)   state_nxt = S_TRAP;
        else if (i_req)   state_nxt = i_two_pass ? S_INIT : S_EXEC;
      end
      S_INIT, S_EXEC, S_TRAP: begin
        if (!i_halt) begin
          if (last) begin
            cnt_nxt   = '0;
            state_nxt = (state == S_INIT) ? S_EXEC : S_ACK;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy     = active;
  assign o_init     = (state == S_INIT);
  assign o_trap     = (state == S_TRAP);
  assign o_en       = active && !i_halt;
  assign o_ack      = (state == S_ACK);
  assign o_cnt      = cnt;
  assign o_cnt0to3  = active && (cnt <= K_LOW);
  assign o_cnt3     = active && (cnt == K_BIT3);
  assign o_cnt7     = active && (cnt == K_BIT7);
  assign o_cnt_done = active && last;

endmodule
